// File: rtl/transform_pkg.sv
// Shared constants for the transform sequencer: FSM encodings, line-pointer
// field positions and the display pad character.
package transform_pkg;

    // FSM state encodings
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PTR_WAIT = 3'd1;
    localparam logic [2:0] CHR_WAIT = 3'd2;
    localparam logic [2:0] EMIT     = 3'd3;
    localparam logic [2:0] NEXT     = 3'd4;
    localparam logic [2:0] FIN      = 3'd5;

    // line_ptr = {len, start}, each one char-memory address wide (8 bits)
    localparam int PTR_LEN_MSB   = 15;
    localparam int PTR_LEN_LSB   = 8;
    localparam int PTR_START_MSB = 7;
    localparam int PTR_START_LSB = 0;

    // Blank character used by the display side for padding
    localparam logic [7:0] PAD_CHAR = 8'h20;

endpackage

// File: rtl/transform_sequencer_rd_wait_timer.sv
// Loadable down-counter covering the registered read latency of the line
// table and character memory. Loaded on the edge that updates the address;
// expired_o rises once RD_LAT further edges have passed, so the consumer
// samples the read data on edge RD_LAT+1 after the address update.
module rd_wait_timer #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic expired_o
);
    localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RD_LAT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on request, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/transform_sequencer.sv
// Walks a range of transform lines: fetches each line's {len,start} pointer,
// then reads that line's character pairs one at a time and streams them out
// as (lhs,rhs) beats with start/end-of-line markers. Fetches are not
// pipelined; one beat is produced per RD_LAT+2 cycles at best.
module transform_sequencer
    import transform_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LINE_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LINE_W-1:0]   first_line,
    input  logic [LINE_W-1:0]   num_lines,
    output logic                busy,
    output logic                done,
    output logic [LINE_W-1:0]   line_idx,
    input  logic [2*ADDR_W-1:0] line_ptr,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_dout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W/2-1:0] out_lhs,
    output logic [DATA_W/2-1:0] out_rhs,
    output logic                out_sol,
    output logic                out_eol,
    output logic [LINE_W-1:0]   out_line
);
    localparam int HALF = DATA_W / 2;

    logic [2:0]        state_q,      state_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic [LINE_W-1:0] num_lines_q,  num_lines_d;
    logic [LINE_W-1:0] lines_done_q, lines_done_d;
    logic [LINE_W-1:0] line_idx_q,   line_idx_d;
    logic [ADDR_W-1:0] len_q,        len_d;
    logic [ADDR_W-1:0] count_q,      count_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic              out_valid_q,  out_valid_d;
    logic [HALF-1:0]   out_lhs_q,    out_lhs_d;
    logic [HALF-1:0]   out_rhs_q,    out_rhs_d;
    logic              out_sol_q,    out_sol_d;
    logic              out_eol_q,    out_eol_d;
    logic [LINE_W-1:0] out_line_q,   out_line_d;

    logic              timer_load;
    logic              timer_expired;

    logic [ADDR_W-1:0] ptr_len;
    logic [ADDR_W-1:0] ptr_start;

    assign ptr_len   = line_ptr[PTR_LEN_MSB:PTR_LEN_LSB];
    assign ptr_start = line_ptr[PTR_START_MSB:PTR_START_LSB];

    // One timer serves both the pointer fetch and the character fetch
    rd_wait_timer #(
        .RD_LAT (RD_LAT)
    ) u_rd_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (timer_load),
        .expired_o (timer_expired)
    );

    // Sequencer next-state and datapath decisions
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        num_lines_d  = num_lines_q;
        lines_done_d = lines_done_q;
        line_idx_d   = line_idx_q;
        len_d        = len_q;
        count_d      = count_q;
        mem_addr_d   = mem_addr_q;
        out_valid_d  = out_valid_q;
        out_lhs_d    = out_lhs_q;
        out_rhs_d    = out_rhs_q;
        out_sol_d    = out_sol_q;
        out_eol_d    = out_eol_q;
        out_line_d   = out_line_q;
        timer_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d       = 1'b1;
                    num_lines_d  = num_lines;
                    lines_done_d = '0;
                    if (num_lines == '0) begin
                        state_d = FIN;
                    end else begin
                        line_idx_d = first_line;
                        timer_load = 1'b1;
                        state_d    = PTR_WAIT;
                    end
                end
            end
            PTR_WAIT: begin
                if (timer_expired) begin
                    len_d = ptr_len;
                    if (ptr_len == '0) begin
                        // Empty line: nothing to emit
                        state_d = NEXT;
                    end else begin
                        mem_addr_d = ptr_start;
                        count_d    = '0;
                        timer_load = 1'b1;
                        state_d    = CHR_WAIT;
                    end
                end
            end
            CHR_WAIT: begin
                if (timer_expired) begin
                    out_lhs_d   = mem_dout[DATA_W-1:HALF];
                    out_rhs_d   = mem_dout[HALF-1:0];
                    out_valid_d = 1'b1;
                    out_sol_d   = (count_q == '0);
                    out_eol_d   = (count_q == (len_q - 1'b1));
                    out_line_d  = line_idx_q;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                // Beat registers stay frozen until the consumer takes it
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = count_q + 1'b1;
                    if ((count_q + 1'b1) < len_q) begin
                        mem_addr_d = mem_addr_q + 1'b1;
                        timer_load = 1'b1;
                        state_d    = CHR_WAIT;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                lines_done_d = lines_done_q + 1'b1;
                if ((lines_done_q + 1'b1) == num_lines_q) begin
                    state_d = FIN;
                end else begin
                    line_idx_d = line_idx_q + 1'b1;
                    timer_load = 1'b1;
                    state_d    = PTR_WAIT;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any sequence immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            num_lines_q  <= '0;
            lines_done_q <= '0;
            line_idx_q   <= '0;
            len_q        <= '0;
            count_q      <= '0;
            mem_addr_q   <= '0;
            out_valid_q  <= 1'b0;
            out_lhs_q    <= '0;
            out_rhs_q    <= '0;
            out_sol_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_line_q   <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            num_lines_q  <= num_lines_d;
            lines_done_q <= lines_done_d;
            line_idx_q   <= line_idx_d;
            len_q        <= len_d;
            count_q      <= count_d;
            mem_addr_q   <= mem_addr_d;
            out_valid_q  <= out_valid_d;
            out_lhs_q    <= out_lhs_d;
            out_rhs_q    <= out_rhs_d;
            out_sol_q    <= out_sol_d;
            out_eol_q    <= out_eol_d;
            out_line_q   <= out_line_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign line_idx  = line_idx_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_lhs   = out_lhs_q;
    assign out_rhs   = out_rhs_q;
    assign out_sol   = out_sol_q;
    assign out_eol   = out_eol_q;
    assign out_line  = out_line_q;

endmodule
